// File: rtl/rtmc_step_seq.sv
// Stepper-motor pattern sequencer: walks a DEPTH-entry pattern table with a
// programmable stride, timed by a delay counter with a linear acceleration ramp.
module rtmc_step_seq #(
  parameter int MC_W  = 8,
  parameter int DEPTH = 16,
  parameter int DLY_W = 16,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pat_we,
  input  logic [IDX_W-1:0] pat_addr,
  input  logic [MC_W-1:0]  pat_wdata,
  output logic [MC_W-1:0]  pat_rdata,
  input  logic             cfg_dir,
  input  logic [2:0]       cfg_step_size,
  input  logic [DLY_W-1:0] cfg_delay_start,
  input  logic [DLY_W-1:0] cfg_delay_min,
  input  logic [DLY_W-1:0] cfg_ramp,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             run,
  input  logic             step_req,
  input  logic             clr_count,
  output logic [MC_W-1:0]  mc,
  output logic [IDX_W-1:0] mc_idx,
  output logic [CNT_W-1:0] step_count,
  output logic [DLY_W-1:0] cur_delay,
  output logic             step_strobe,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [MC_W-1:0]  table_r [DEPTH];
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [MC_W-1:0]  mc_r;
  logic [MC_W-1:0]  pat_rdata_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] count_r;
  logic [DLY_W-1:0] cur_delay_r;
  logic [DLY_W-1:0] dcnt_r;
  logic             strobe_r;
  logic             busy_r;
  logic             done_r;

  logic             step_s;
  logic             load_s;
  logic             target_zero_s;
  logic [3:0]       stride_s;
  logic [IDX_W+3:0] idx_wide_s;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [CNT_W-1:0] count_inc_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [DLY_W:0]   ramp_floor_s;
  logic [DLY_W-1:0] delay_ramped_s;
  logic [DLY_W-1:0] delay_nxt_s;
  logic [DLY_W-1:0] dcnt_nxt_s;

  assign target_zero_s = (cfg_target == {CNT_W{1'b0}});
  assign stride_s      = {1'b0, cfg_step_size} + 4'd1;
  assign count_inc_s   = (&count_r) ? count_r : count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign ramp_floor_s  = {1'b0, cfg_delay_min} + {1'b0, cfg_ramp};

  // State transitions and step/load decisions
  always_comb begin
    state_nxt_s = state_r;
    step_s      = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          if (target_zero_s || (count_r < cfg_target)) begin
            state_nxt_s = ST_RUN;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else if (step_req) begin
          step_s = 1'b1;
        end else begin
          step_s = 1'b0;
        end
      end
      ST_RUN: begin
        // A falling run wins over a step that is due on the same edge.
        if (!run) begin
          state_nxt_s = ST_IDLE;
        end else if (dcnt_r == {DLY_W{1'b0}}) begin
          step_s = 1'b1;
          if (!target_zero_s && !clr_count && (count_inc_s == cfg_target)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!run) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next index, count, delay and delay-counter values
  always_comb begin
    if (cfg_dir) begin
      idx_wide_s = {4'd0, idx_r} - {{IDX_W{1'b0}}, stride_s};
    end else begin
      idx_wide_s = {4'd0, idx_r} + {{IDX_W{1'b0}}, stride_s};
    end
    idx_nxt_s = step_s ? idx_wide_s[IDX_W-1:0] : idx_r;

    if (clr_count) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (step_s) begin
      count_nxt_s = count_inc_s;
    end else begin
      count_nxt_s = count_r;
    end

    // Compared one bit wider so min+ramp cannot wrap.
    if ({1'b0, cur_delay_r} >= ramp_floor_s) begin
      delay_ramped_s = cur_delay_r - cfg_ramp;
    end else begin
      delay_ramped_s = cfg_delay_min;
    end

    if (load_s) begin
      delay_nxt_s = cfg_delay_start;
    end else if (step_s) begin
      delay_nxt_s = delay_ramped_s;
    end else begin
      delay_nxt_s = cur_delay_r;
    end

    if (load_s) begin
      dcnt_nxt_s = cfg_delay_start;
    end else if ((state_r == ST_RUN) && run) begin
      if (dcnt_r == {DLY_W{1'b0}}) begin
        dcnt_nxt_s = delay_ramped_s;
      end else begin
        dcnt_nxt_s = dcnt_r - {{(DLY_W-1){1'b0}}, 1'b1};
      end
    end else begin
      dcnt_nxt_s = dcnt_r;
    end
  end

  // Pattern table storage and registered read ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= {MC_W{1'b0}};
      end
      mc_r        <= {MC_W{1'b0}};
      pat_rdata_r <= {MC_W{1'b0}};
    end else begin
      if (pat_we) begin
        table_r[pat_addr] <= pat_wdata;
      end
      mc_r        <= table_r[idx_r];
      pat_rdata_r <= table_r[pat_addr];
    end
  end

  // Sequencer state, counters and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      cur_delay_r <= {DLY_W{1'b0}};
      dcnt_r      <= {DLY_W{1'b0}};
      strobe_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      count_r     <= count_nxt_s;
      cur_delay_r <= delay_nxt_s;
      dcnt_r      <= dcnt_nxt_s;
      strobe_r    <= step_s;
      busy_r      <= (state_nxt_s == ST_RUN);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign pat_rdata   = pat_rdata_r;
  assign mc          = mc_r;
  assign mc_idx      = idx_r;
  assign step_count  = count_r;
  assign cur_delay   = cur_delay_r;
  assign step_strobe = strobe_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_rtmc_step_seq.sv
// Directed self-checking bench for rtmc_step_seq (DEPTH=16, MC_W=8).
module tb_rtmc_step_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pat_we;
  logic [3:0]  pat_addr;
  logic [7:0]  pat_wdata;
  logic [7:0]  pat_rdata;
  logic        cfg_dir;
  logic [2:0]  cfg_step_size;
  logic [15:0] cfg_delay_start;
  logic [15:0] cfg_delay_min;
  logic [15:0] cfg_ramp;
  logic [15:0] cfg_target;
  logic        run;
  logic        step_req;
  logic        clr_count;
  logic [7:0]  mc;
  logic [3:0]  mc_idx;
  logic [15:0] step_count;
  logic [15:0] cur_delay;
  logic        step_strobe;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rtmc_step_seq #(.MC_W(8), .DEPTH(16), .DLY_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_wdata(pat_wdata), .pat_rdata(pat_rdata),
    .cfg_dir(cfg_dir), .cfg_step_size(cfg_step_size), .cfg_delay_start(cfg_delay_start),
    .cfg_delay_min(cfg_delay_min), .cfg_ramp(cfg_ramp), .cfg_target(cfg_target),
    .run(run), .step_req(step_req), .clr_count(clr_count),
    .mc(mc), .mc_idx(mc_idx), .step_count(step_count), .cur_delay(cur_delay),
    .step_strobe(step_strobe), .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until step_strobe is seen; n is the number of edges taken.
  task automatic wait_strobe(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (step_strobe) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ns;
    int rev_exp [6] = '{13, 10, 7, 4, 1, 14};

    rst_n = 1'b0; pat_we = 1'b0; pat_addr = 4'd0; pat_wdata = 8'd0;
    cfg_dir = 1'b0; cfg_step_size = 3'd0; cfg_delay_start = 16'd0;
    cfg_delay_min = 16'd0; cfg_ramp = 16'd0; cfg_target = 16'd0;
    run = 1'b0; step_req = 1'b0; clr_count = 1'b0;
    tick(); tick();
    check_eq("rst_mc", mc, 0);
    check_eq("rst_idx", mc_idx, 0);
    check_eq("rst_count", step_count, 0);
    check_eq("rst_delay", cur_delay, 0);
    check_eq("rst_strobe", step_strobe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rdata", pat_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Load table[i] = i+1
    for (int i = 0; i < 16; i++) begin
      pat_we = 1'b1; pat_addr = 4'(i); pat_wdata = 8'(i + 1);
      tick();
    end
    pat_we = 1'b0; pat_addr = 4'd5;
    tick();
    check_eq("rdata_5", pat_rdata, 6);
    pat_addr = 4'd15;
    tick();
    check_eq("rdata_15", pat_rdata, 16);
    check_eq("mc_idle", mc, 1);

    // Forward walk, period 4
    cfg_delay_start = 16'd3;
    run = 1'b1;
    tick();
    check_eq("fwd_busy", busy, 1);
    check_eq("fwd_delay", cur_delay, 3);
    for (int s = 1; s <= 17; s++) begin
      tick(); tick(); tick();
      check_eq("fwd_gap", step_strobe, 0);
      tick();
      check_eq("fwd_strobe", step_strobe, 1);
      check_eq("fwd_mc", mc, ((s - 1) % 16) + 1);
      check_eq("fwd_count", step_count, s);
    end
    run = 1'b0;
    tick();
    check_eq("fwd_stop_busy", busy, 0);
    check_eq("fwd_stop_count", step_count, 17);
    check_eq("fwd_stop_idx", mc_idx, 1);

    // Run dropped on the edge a step is due
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check_eq("clr_idle", step_count, 0);
    run = 1'b1;
    tick(); tick(); tick(); tick();
    run = 1'b0;
    tick();
    check_eq("drop_strobe", step_strobe, 0);
    check_eq("drop_count", step_count, 0);
    check_eq("drop_busy", busy, 0);
    check_eq("drop_idx", mc_idx, 1);

    // Single steps in IDLE
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      check_eq("ss_strobe", step_strobe, 1);
      tick();
      check_eq("ss_gap", step_strobe, 0);
    end
    check_eq("ss_count", step_count, 3);
    check_eq("ss_idx", mc_idx, 4);
    cfg_dir = 1'b1; cfg_step_size = 3'd3;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    check_eq("ss_rev_idx", mc_idx, 0);

    // Reverse walk, stride 3, period 1
    cfg_step_size = 3'd2; cfg_delay_start = 16'd0;
    run = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("rev_idx", mc_idx, rev_exp[k]);
      check_eq("rev_strobe", step_strobe, 1);
    end
    run = 1'b0;
    tick();
    check_eq("rev_stop_idx", mc_idx, 14);
    check_eq("rev_stop_busy", busy, 0);

    // Ramp 10 -> 7 -> 4 -> 4, step_req ignored in RUN
    cfg_dir = 1'b0; cfg_step_size = 3'd0;
    cfg_delay_start = 16'd10; cfg_delay_min = 16'd4; cfg_ramp = 16'd3;
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    run = 1'b1;
    tick();
    check_eq("ramp_busy", busy, 1);
    check_eq("ramp_delay0", cur_delay, 10);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check_eq("ramp_req_ign", step_count, 0);
    wait_strobe(n);
    check_eq("ramp_int1", n, 10);
    check_eq("ramp_count1", step_count, 1);
    check_eq("ramp_delay1", cur_delay, 7);
    wait_strobe(n);
    check_eq("ramp_int2", n, 8);
    check_eq("ramp_delay2", cur_delay, 4);
    wait_strobe(n);
    check_eq("ramp_int3", n, 5);
    check_eq("ramp_delay3", cur_delay, 4);
    wait_strobe(n);
    check_eq("ramp_int4", n, 5);
    run = 1'b0;
    tick();
    check_eq("ramp_idx", mc_idx, 2);

    // Target stop after 5 steps
    cfg_delay_start = 16'd1; cfg_delay_min = 16'd0; cfg_ramp = 16'd0; cfg_target = 16'd5;
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    run = 1'b1;
    ns = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (step_strobe) begin
        ns++;
        if (ns == 5) check_eq("tgt_done_edge", done, 1);
      end
    end
    check_eq("tgt_strobes", ns, 5);
    check_eq("tgt_done", done, 1);
    check_eq("tgt_busy", busy, 0);
    check_eq("tgt_count", step_count, 5);
    check_eq("tgt_idx", mc_idx, 7);
    run = 1'b0;
    tick();
    check_eq("tgt_idle_done", done, 0);
    run = 1'b1;
    tick();
    check_eq("tgt_again_done", done, 1);
    check_eq("tgt_again_busy", busy, 0);
    check_eq("tgt_again_strobe", step_strobe, 0);
    check_eq("tgt_again_count", step_count, 5);
    run = 1'b0;
    tick();

    // clr_count coincident with a step
    cfg_target = 16'd0; cfg_delay_start = 16'd2;
    run = 1'b1;
    tick(); tick(); tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check_eq("clr_step_strobe", step_strobe, 1);
    check_eq("clr_step_count", step_count, 0);
    check_eq("clr_step_idx", mc_idx, 8);
    run = 1'b0;
    tick();

    // Write to the current index shows on mc one edge later
    pat_we = 1'b1; pat_addr = 4'd8; pat_wdata = 8'hA5;
    tick();
    pat_we = 1'b0;
    check_eq("wr_mc_old", mc, 8'h09);
    tick();
    check_eq("wr_mc_new", mc, 8'hA5);
    check_eq("wr_rdata", pat_rdata, 8'hA5);

    // Asynchronous reset mid-RUN
    cfg_delay_start = 16'd5;
    run = 1'b1;
    tick(); tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_mc", mc, 0);
    check_eq("arst_idx", mc_idx, 0);
    check_eq("arst_count", step_count, 0);
    check_eq("arst_delay", cur_delay, 0);
    check_eq("arst_strobe", step_strobe, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_rdata", pat_rdata, 0);
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    pat_addr = 4'd8;
    tick();
    check_eq("arst_tbl8", pat_rdata, 0);
    check_eq("arst_mc_after", mc, 0);
    pat_addr = 4'd3;
    tick();
    check_eq("arst_tbl3", pat_rdata, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
